// File: rtl/usb_buf_stream_bridge.sv
// Application-side initiator for the USB device core endpoint buffers: OUT buffer -> byte stream, byte stream -> IN buffer.
// Optional partial-IN-packet flush timer is built when USB_BUF_IN_TIMEOUT_EN is defined.
module usb_buf_stream_bridge #(
   parameter int unsigned MAX_PKT        = 512,
   parameter int unsigned OUT_FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       ext_clk,
   input  logic       reset_n,
   input  logic       buf_out_hasdata,
   input  logic [9:0] buf_out_len,
   output logic [8:0] buf_out_addr,
   input  logic [7:0] buf_out_q,
   output logic       buf_out_arm,
   input  logic       buf_out_arm_ack,
   input  logic       buf_in_ready,
   output logic [8:0] buf_in_addr,
   output logic [7:0] buf_in_data,
   output logic       buf_in_wren,
   output logic       buf_in_commit,
   output logic [9:0] buf_in_commit_len,
   input  logic       buf_in_commit_ack,
   output logic [7:0] out_tdata,
   output logic       out_tvalid,
   input  logic       out_tready,
   output logic       out_tlast,
   input  logic [7:0] in_tdata,
   input  logic       in_tvalid,
   output logic       in_tready,
   input  logic       in_tlast,
   output logic       zlp_seen
);

   localparam int unsigned AW        = $clog2(OUT_FIFO_DEPTH);
   localparam logic [AW:0] FIFO_FULL = (AW+1)'(OUT_FIFO_DEPTH);
   localparam logic [9:0]  MAX_PKT_C = 10'(MAX_PKT);

   typedef enum logic [1:0] {O_IDLE, O_READ, O_DRAIN, O_ARM} o_state_t;
   typedef enum logic [1:0] {I_WAIT, I_FILL, I_COMMIT}       i_state_t;

   // ---------------- OUT path ----------------
   o_state_t      o_state, o_next;
   logic [9:0]    len_q, rd_ptr;
   logic          rd_vld_q, rd_last_q, rd_issue, rd_is_last, zlp_q;
   logic [8:0]    fifo_mem [OUT_FIFO_DEPTH];
   logic [AW-1:0] f_wp, f_rp;
   logic [AW:0]   f_cnt;
   logic          f_push, f_pop;

   assign rd_is_last = (rd_ptr == len_q - 10'd1);
   // A read still in flight already owns a FIFO slot, so it counts toward occupancy.
   assign rd_issue   = (o_state == O_READ) && ((f_cnt + (AW+1)'(rd_vld_q)) < FIFO_FULL);
   assign f_push     = rd_vld_q;
   assign f_pop      = out_tvalid && out_tready;

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) o_state <= O_IDLE;
      else          o_state <= o_next;
   end

   always_comb begin
      o_next = o_state;
      unique case (o_state)
         O_IDLE:  if (buf_out_hasdata) o_next = (buf_out_len == '0) ? O_ARM : O_READ;
         O_READ:  if (rd_issue && rd_is_last) o_next = O_DRAIN;
         O_DRAIN: if (rd_vld_q) o_next = O_ARM;
         O_ARM:   if (buf_out_arm_ack) o_next = O_IDLE;
         default: o_next = O_IDLE;
      endcase
   end

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q     <= '0;
         rd_ptr    <= '0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
         zlp_q     <= 1'b0;
      end else begin
         rd_vld_q  <= rd_issue;
         rd_last_q <= rd_issue && rd_is_last;
         zlp_q     <= (o_state == O_IDLE) && buf_out_hasdata && (buf_out_len == '0);
         if (o_state == O_IDLE && buf_out_hasdata) begin
            len_q  <= buf_out_len;
            rd_ptr <= '0;
         end else if (rd_issue) begin
            rd_ptr <= rd_ptr + 10'd1;
         end
      end
   end

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         f_wp  <= '0;
         f_rp  <= '0;
         f_cnt <= '0;
      end else begin
         if (f_push) f_wp <= f_wp + AW'(1);
         if (f_pop)  f_rp <= f_rp + AW'(1);
         f_cnt <= f_cnt + (AW+1)'(f_push) - (AW+1)'(f_pop);
      end
   end

   always_ff @(posedge ext_clk) begin
      if (f_push) fifo_mem[f_wp] <= {rd_last_q, buf_out_q};
   end

   assign buf_out_addr = rd_ptr[8:0];
   assign buf_out_arm  = (o_state == O_ARM);
   assign zlp_seen     = zlp_q;
   assign out_tvalid   = (f_cnt != '0);
   assign out_tdata    = out_tvalid ? fifo_mem[f_rp][7:0] : '0;
   assign out_tlast    = out_tvalid && fifo_mem[f_rp][8];

   // ---------------- IN path ----------------
   i_state_t   i_state, i_next;
   logic [9:0] wr_cnt;
   logic       in_acc, in_full, to_hit;

   assign in_acc  = in_tvalid && (i_state == I_FILL);
   assign in_full = (wr_cnt + 10'd1 == MAX_PKT_C);

`ifdef USB_BUF_IN_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   assign to_hit = (i_state == I_FILL) && !in_acc && (wr_cnt != '0) &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n)                                        to_cnt <= '0;
      else if (i_state != I_FILL || in_acc || wr_cnt == '0) to_cnt <= '0;
      else                                                 to_cnt <= to_cnt + TW'(1);
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign to_hit             = 1'b0;
`endif

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) i_state <= I_WAIT;
      else          i_state <= i_next;
   end

   always_comb begin
      i_next = i_state;
      unique case (i_state)
         I_WAIT:   if (buf_in_ready) i_next = I_FILL;
         I_FILL:   if ((in_acc && (in_tlast || in_full)) || to_hit) i_next = I_COMMIT;
         I_COMMIT: if (buf_in_commit_ack) i_next = I_WAIT;
         default:  i_next = I_WAIT;
      endcase
   end

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n)                            wr_cnt <= '0;
      else if (i_state == I_WAIT && buf_in_ready) wr_cnt <= '0;
      else if (in_acc)                         wr_cnt <= wr_cnt + 10'd1;
   end

   // wr_cnt is frozen in I_COMMIT, so it doubles as the held commit length.
   assign in_tready         = (i_state == I_FILL);
   assign buf_in_wren       = in_acc;
   assign buf_in_addr       = wr_cnt[8:0];
   assign buf_in_data       = in_acc ? in_tdata : '0;
   assign buf_in_commit     = (i_state == I_COMMIT);
   assign buf_in_commit_len = buf_in_commit ? wr_cnt : '0;

endmodule

// File: doc/usb_buf_stream_bridge.md
Name: usb_buf_stream_bridge

Overview:
- Application-side initiator of the USB device core's endpoint buffer interface, facing the core's buffer responder.
- OUT path: drains each received packet from the core's OUT buffer into a byte stream (valid/ready/last), then re-arms the buffer.
- IN path: fills the core's IN buffer from a byte stream and commits packets for transmission.
- Sits between the USB device core and user logic, in the ext_clk domain.

Parameters:
- MAX_PKT, 512: maximum IN packet length in bytes, legal range 1..512; a full packet is committed automatically.
- OUT_FIFO_DEPTH, 4: depth of the OUT-path read-ahead FIFO, power of two, ≥2.
- TIMEOUT_CYCLES, 1024: idle cycles before a partial IN packet is flushed (optional feature only).

Ports:
- ext_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- buf_out_hasdata  in  1  core holds a received OUT packet
- buf_out_len  in  10  byte length of held OUT packet (0..512)
- buf_out_addr  out  9  OUT buffer read address
- buf_out_q  in  8  OUT buffer read data, valid one cycle after buf_out_addr
- buf_out_arm  out  1  release OUT buffer to core
- buf_out_arm_ack  in  1  core accepted arm
- buf_in_ready  in  1  core IN buffer free for filling
- buf_in_addr  out  9  IN buffer write address
- buf_in_data  out  8  IN buffer write data
- buf_in_wren  out  1  IN buffer write strobe
- buf_in_commit  out  1  request transmission of filled IN buffer
- buf_in_commit_len  out  10  committed byte count
- buf_in_commit_ack  in  1  core accepted commit
- out_tdata  out  8  OUT stream byte
- out_tvalid  out  1  OUT stream valid
- out_tready  in  1  OUT stream ready
- out_tlast  out  1  last byte of OUT packet
- in_tdata  in  8  IN stream byte
- in_tvalid  in  1  IN stream valid
- in_tready  out  1  IN stream ready
- in_tlast  in  1  last byte of IN packet
- zlp_seen  out  1  one-cycle pulse when a zero-length OUT packet is released

Behaviour:
- Reset (async assert, sync release): every output is 0; FIFO is emptied; both FSMs enter IDLE.
- OUT FSM states: O_IDLE, O_READ, O_DRAIN, O_ARM.
  - O_IDLE: on buf_out_hasdata=1, latch len = buf_out_len and clear rd_ptr. If len==0, go to O_ARM and pulse zlp_seen; otherwise go to O_READ.
  - O_READ: issue one read per cycle only while (FIFO count + reads in flight) < OUT_FIFO_DEPTH. buf_out_addr = rd_ptr. Each returning byte is pushed into the FIFO with last = (byte index == len-1). After issuing address len-1, go to O_DRAIN.
  - O_DRAIN: wait for the final in-flight byte to land in the FIFO, then go to O_ARM. The FIFO may still hold bytes.
  - O_ARM: hold buf_out_arm=1 until buf_out_arm_ack=1, then deassert it and go to O_IDLE. The core clears buf_out_hasdata on the ack edge, so O_IDLE does not re-sample hasdata until the following cycle.
  - The next packet may be read while the FIFO still drains the previous one. Stream order and tlast placement are preserved.
- OUT stream: out_tvalid = FIFO not empty; a transfer occurs on out_tvalid & out_tready. out_tdata and out_tlast hold while stalled. Bytes are never dropped or duplicated under backpressure.
- IN FSM states: I_WAIT, I_FILL, I_COMMIT.
  - I_WAIT: on buf_in_ready=1, clear wr_cnt and go to I_FILL.
  - I_FILL: in_tready = 1. Each accepted byte gives buf_in_wren=1, buf_in_addr=wr_cnt, buf_in_data=in_tdata, then wr_cnt increments. Go to I_COMMIT when the accepted byte has in_tlast=1 or wr_cnt+1 == MAX_PKT. The commit length is the post-increment count.
  - I_COMMIT: in_tready = 0; hold buf_in_commit=1 and buf_in_commit_len stable until buf_in_commit_ack, then go to I_WAIT.
  - The core drops buf_in_ready on commit_ack; the bridge ignores buf_in_ready in the ack cycle.
- A packet split at MAX_PKT continues in the next buffer. tlast is honoured wherever it falls.
- in_tready is 0 in I_WAIT and I_COMMIT, so no byte is ever accepted without a buffer.
- Widths: wr_cnt and len are 10 bits; addresses are the low 9 bits. A length of 512 is legal; address 511 is the highest written or read.
- The IN and OUT paths are fully independent. Simultaneous activity on both is legal.

Optional Feature:
- Macro: USB_BUF_IN_TIMEOUT_EN.
- Defined:
  - In I_FILL with wr_cnt>0, a counter increments each cycle with no accepted byte and resets on any accepted byte.
  - On reaching TIMEOUT_CYCLES, the FSM goes to I_COMMIT with len=wr_cnt.
  - An empty buffer never times out.
- Undefined: no counter is present; commit occurs only on tlast or at MAX_PKT.

Test Plan:
- OUT len=5, bytes 0x10..0x14, out_tready=1 → 5 stream bytes in order, tlast on 0x14, buf_out_arm held until ack, then one arm pulse sequence.
- OUT len=0 → no stream output, zlp_seen pulses once, arm/ack completes, FSM returns to O_IDLE.
- OUT len=512 with out_tready toggling 1/0 each cycle → all 512 bytes delivered, no loss or duplication; FIFO never exceeds OUT_FIFO_DEPTH; arm only after address 511 data is captured.
- IN 3 bytes 0xA0,0xA1,0xA2 with tlast on the third → writes at addresses 0..2, then commit_len=3 held until ack.
- IN 700-byte stream, MAX_PKT=512 → first commit_len=512, wait for buf_in_ready, second commit_len=188; in_tready=0 during commits.
- With USB_BUF_IN_TIMEOUT_EN and TIMEOUT_CYCLES=16: 2 bytes, then in_tvalid=0 for 16 cycles → commit_len=2. Without the macro → no commit.
